psum_drain: RTL and testbench

- Reads the NUM_COLS PSUM_ROW_MEMs after pe_array finishes a tile; it is the read-side counterpart of the pe_array psum write path.
- Requantizes each 32-bit signed psum to 8-bit signed (rounding shift plus saturation).
- Streams results out as a valid/ready byte stream toward the AXI output path.
- Asserts done once the last byte is accepted.

---
 rtl/psum_drain_if.sv | 27 ++
 rtl/psum_drain.sv | 216 +++++++++++++++++++++
 tb/tb_psum_drain.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_drain_if.sv
// Bus bundle for psum_drain: psum row-mem read port plus the quantized output byte stream.
// master = drain side, slave = row mems / stream consumer.
`timescale 1ns/1ps
interface psum_drain_if #(
    parameter int unsigned ADDR_PSUM = 12,
    parameter int unsigned PSUM_BW   = 32,
    parameter int unsigned OUT_BW    = 8,
    parameter int unsigned NUM_COLS  = 32
);
    logic [NUM_COLS-1:0]         psum_rd_en;
    logic [ADDR_PSUM-1:0]        psum_rd_addr;
    logic [PSUM_BW*NUM_COLS-1:0] psum_rd_data;
    logic [OUT_BW-1:0]           out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output psum_rd_en, psum_rd_addr, out_data, out_valid, out_last,
        input  psum_rd_data, out_ready
    );

    modport slave (
        input  psum_rd_en, psum_rd_addr, out_data, out_valid, out_last,
        output psum_rd_data, out_ready
    );
endinterface

// File: rtl/psum_drain.sv
// Drains the psum row mems after a tile, requantizes 32b psums to 8b and streams them out.
// Optional fused ReLU on the requantized value: define PSUM_DRAIN_RELU_EN.
`timescale 1ns/1ps
module psum_drain #(
    parameter int unsigned ADDR_PSUM = 12,
    parameter int unsigned PSUM_BW   = 32,
    parameter int unsigned OUT_BW    = 8,
    parameter int unsigned NUM_COLS  = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [5:0]  IMG_H,
    input  logic [5:0]  IMG_W,
    input  logic [7:0]  OC,
    input  logic [4:0]  SHIFT,
    output logic        busy,
    output logic        done,
    psum_drain_if.master bus
);

    localparam int unsigned COL_W  = $clog2(NUM_COLS);
    localparam int unsigned NW_W   = ADDR_PSUM + 1;
    localparam int unsigned PROD_W = 14;
    localparam int unsigned EXT_W  = PSUM_BW + 1;

    localparam logic [PROD_W-1:0]       DEPTH  = PROD_W'(1 << ADDR_PSUM);
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((1 << (OUT_BW - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [5:0]           col_q, col_d;
    logic [ADDR_PSUM-1:0] addr_q, addr_d;
    logic [5:0]           h_q, h_d;
    logic [NW_W-1:0]      n_q, n_d;
    logic [4:0]           shift_q, shift_d;

    logic                 d_vld_q;
    logic [COL_W-1:0]     d_col_q;
    logic                 d_last_q;
    logic [OUT_BW-1:0]    fifo_data_q [2];
    logic                 fifo_last_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           fifo_cnt_q;

    logic [PROD_W-1:0]    prod_c;
    logic [NW_W-1:0]      n_in_c;
    logic [5:0]           h_in_c;
    logic                 pop_c, head_last_c, credit_c;
    logic [2:0]           level_c;
    logic                 addr_last_c, col_last_c;
    logic                 issue_c, rd_last_c;
    logic [PSUM_BW-1:0]   x_c;
    logic [OUT_BW-1:0]    q_c;

    // Tile geometry from the start-time inputs; word count clamped to the mem depth.
    assign prod_c = PROD_W'(IMG_W) * PROD_W'(OC);
    assign n_in_c = (prod_c > DEPTH) ? NW_W'(DEPTH) : NW_W'(prod_c);
    assign h_in_c = (IMG_H > 6'(NUM_COLS)) ? 6'(NUM_COLS) : IMG_H;

    assign pop_c       = (fifo_cnt_q != 2'd0) && bus.out_ready;
    assign head_last_c = fifo_last_q[rd_ptr_q];

    // Slots committed = buffered words + the read whose data is on the bus now, less this cycle's pop.
    assign level_c  = 3'(fifo_cnt_q) + 3'(d_vld_q) - 3'(pop_c);
    assign credit_c = (level_c < 3'd2);

    assign addr_last_c = ({1'b0, addr_q} == (n_q - NW_W'(1)));
    assign col_last_c  = (col_q == (h_q - 6'd1));

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        col_d     = col_q;
        addr_d    = addr_q;
        h_d       = h_q;
        n_d       = n_q;
        shift_d   = shift_q;
        issue_c   = 1'b0;
        rd_last_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (IMG_H == 6'd0 || IMG_W == 6'd0 || OC == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        col_d   = '0;
                        addr_d  = '0;
                        h_d     = h_in_c;
                        n_d     = n_in_c;
                        shift_d = SHIFT;
                    end
                end
            end
            S_RUN: begin
                issue_c = credit_c;
                if (credit_c) begin
                    rd_last_c = addr_last_c && col_last_c;
                    if (addr_last_c) begin
                        addr_d = '0;
                        col_d  = col_q + 6'd1;
                    end else begin
                        addr_d = addr_q + ADDR_PSUM'(1);
                    end
                    if (addr_last_c && col_last_c) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (pop_c && head_last_c) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            col_q   <= '0;
            addr_q  <= '0;
            h_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            h_q     <= h_d;
            n_q     <= n_d;
            shift_q <= shift_d;
        end
    end

    // Read data is valid the cycle after the read; pick the column recorded with it.
    assign x_c = bus.psum_rd_data[PSUM_BW*d_col_q +: PSUM_BW];

    always_comb begin
        logic signed [EXT_W-1:0] xe;
        logic signed [EXT_W-1:0] rnd;
        logic signed [EXT_W-1:0] t;
        xe  = {x_c[PSUM_BW-1], x_c};
        rnd = '0;
        if (shift_q != 5'd0) begin
            rnd = EXT_W'(1) << (shift_q - 5'd1);
        end
        t = (xe + rnd) >>> shift_q;
`ifdef PSUM_DRAIN_RELU_EN
        if (t < 0) begin
            t = '0;
        end
`endif
        if (t > SAT_HI) begin
            q_c = SAT_HI[OUT_BW-1:0];
        end else if (t < SAT_LO) begin
            q_c = SAT_LO[OUT_BW-1:0];
        end else begin
            q_c = t[OUT_BW-1:0];
        end
    end

    // Return-data stage and 2-entry output FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_vld_q     <= 1'b0;
            d_col_q     <= '0;
            d_last_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            d_vld_q  <= issue_c;
            d_col_q  <= col_q[COL_W-1:0];
            d_last_q <= rd_last_c;
            if (d_vld_q) begin
                fifo_data_q[wr_ptr_q] <= q_c;
                fifo_last_q[wr_ptr_q] <= d_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(d_vld_q) - 2'(pop_c);
        end
    end

    assign bus.psum_rd_en   = issue_c ? (NUM_COLS'(1) << col_q[COL_W-1:0]) : '0;
    assign bus.psum_rd_addr = addr_q;
    assign bus.out_valid    = (fifo_cnt_q != 2'd0);
    assign bus.out_data     = fifo_data_q[rd_ptr_q];
    assign bus.out_last     = (fifo_cnt_q != 2'd0) && head_last_c;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: behavioural row mems, reference requantizer, decoupled monitor.
`timescale 1ns/1ps
module tb_psum_drain;
    localparam int unsigned ADDR_PSUM = 12;
    localparam int unsigned PSUM_BW   = 32;
    localparam int unsigned OUT_BW    = 8;
    localparam int unsigned NUM_COLS  = 32;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [5:0] img_h = '0;
    logic [5:0] img_w = '0;
    logic [7:0] oc = '0;
    logic [4:0] shift = '0;
    logic       busy, done;

    psum_drain_if #(.ADDR_PSUM(ADDR_PSUM), .PSUM_BW(PSUM_BW), .OUT_BW(OUT_BW), .NUM_COLS(NUM_COLS)) bus ();

    psum_drain #(.ADDR_PSUM(ADDR_PSUM), .PSUM_BW(PSUM_BW), .OUT_BW(OUT_BW), .NUM_COLS(NUM_COLS)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .IMG_H(img_h), .IMG_W(img_w), .OC(oc), .SHIFT(shift),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [NUM_COLS][4096];
    logic [8:0]  exp_q [$];
    int          rd_q [$];
    int          hs_cyc_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          issued = 0;
    int          hs = 0;
    int          ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Row mems: 1-cycle read latency, only the enabled column updates.
    always @(posedge clk) begin
        if (!resetn) begin
            bus.psum_rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_COLS; i++) begin
                if (bus.psum_rd_en[i]) bus.psum_rd_data[i*PSUM_BW +: PSUM_BW] <= mem[i][bus.psum_rd_addr];
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_q(input logic [31:0] w, input int s);
        longint x, t;
        x = longint'(signed'(w));
        if (s > 0) t = (x + (longint'(1) << (s - 1))) >>> s;
        else       t = x;
`ifdef PSUM_DRAIN_RELU_EN
        if (t < 0) t = 0;
`endif
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return 8'(t);
    endfunction

    task automatic model_push(input int h, input int w, input int o, input int s);
        int n;
        n = w * o;
        if (n > 4096) n = 4096;
        for (int c = 0; c < h; c++) begin
            for (int a = 0; a < n; a++) begin
                exp_q.push_back({1'((c == h - 1) && (a == n - 1)), ref_q(mem[c][a], s)});
                rd_q.push_back(c * 4096 + a);
            end
        end
    endtask

    task automatic fill_pattern(input int h, input int n);
        for (int c = 0; c < h; c++)
            for (int a = 0; a < n; a++) mem[c][a] = 32'(c * 16 + a);
    endtask

    task automatic fill_random(input int h, input int n);
        for (int c = 0; c < h; c++)
            for (int a = 0; a < n; a++)
                if ($urandom_range(0, 3) == 0) mem[c][a] = $urandom;
                else mem[c][a] = 32'(int'($urandom_range(0, 4000)) - 2000);
    endtask

    // Pulse start so it is sampled at the next edge; the model is loaded only when a drain is expected.
    task automatic do_start(input int h, input int w, input int o, input int s, input bit expect_run);
        @(posedge clk); #1;
        img_h = 6'(h); img_w = 6'(w); oc = 8'(o); shift = 5'(s); start = 1'b1;
        if (expect_run) model_push(h, w, o, s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", rd_q.size(), 0);
    endtask

    // Consumer ready pattern.
    initial begin
        int ph;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       begin bus.out_ready = (ph == 0); ph = (ph + 1) % 3; end
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: read-order scoreboard, output scoreboard, stall stability, read-ahead bound.
    initial begin
        logic             stall_prev;
        logic [7:0]       prev_data;
        logic             prev_last;
        logic [8:0]       e;
        int               r;
        logic [NUM_COLS-1:0] en_e;
        stall_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                issued = 0; hs = 0; stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", bus.out_valid, 1);
                    chk("stall_data", bus.out_data, prev_data);
                    chk("stall_last", bus.out_last, prev_last);
                end
                if (bus.out_valid && bus.out_ready) begin
                    hs++;
                    hs_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL extra_word: got data %0d with no word expected (cycle %0d)", bus.out_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", longint'(signed'(bus.out_data)), longint'(signed'(e[7:0])));
                        chk("out_last", bus.out_last, e[8]);
                    end
                end
                if (bus.psum_rd_en != '0) begin
                    issued++;
                    if (rd_q.size() == 0) begin
                        chk("unexpected_read", longint'(bus.psum_rd_en), 0);
                    end else begin
                        r = rd_q.pop_front();
                        en_e = '0;
                        en_e[r / 4096] = 1'b1;
                        chk("rd_en", longint'(bus.psum_rd_en), longint'(en_e));
                        chk("rd_addr", bus.psum_rd_addr, r % 4096);
                    end
                    chk("reads_ahead_le2", (issued - hs) <= 2, 1);
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int n;
        int h, w, o, s;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", longint'(bus.psum_rd_en), 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        @(posedge clk); #1 resetn = 1'b1;

        // Single word pass-through with exact cycle timing.
        ready_mode = 0;
        mem[0][0] = 32'h0000_0005;
        do_start(1, 1, 1, 0, 1'b1);
        @(negedge clk);
        chk("t1_busy_c1", busy, 1);
        chk("t1_rd_en_c1", longint'(bus.psum_rd_en), 1);
        @(negedge clk);
        chk("t1_valid_c2", bus.out_valid, 0);
        @(negedge clk);
        chk("t1_valid_c3", bus.out_valid, 1);
        chk("t1_data_c3", bus.out_data, 5);
        chk("t1_last_c3", bus.out_last, 1);
        @(negedge clk);
        chk("t1_done_c4", done, 1);
        chk("t1_busy_c4", busy, 0);
        @(negedge clk);
        chk("t1_done_c5", done, 0);

        // Rounding and saturation.
        mem[0][0] = 32'(24); mem[0][1] = 32'(-24); mem[0][2] = 32'(5000); mem[0][3] = 32'(-5000);
        do_start(1, 4, 1, 4, 1'b1);
        wait_done(100);

        // Full stream order, one word per cycle.
        fill_pattern(2, 6);
        hs_cyc_q.delete();
        do_start(2, 2, 3, 0, 1'b1);
        wait_done(100);
        chk("t3_word_count", hs_cyc_q.size(), 12);
        if (hs_cyc_q.size() == 12) chk("t3_back_to_back", hs_cyc_q[11] - hs_cyc_q[0], 11);

        // Backpressure on the same tile.
        ready_mode = 1;
        do_start(2, 2, 3, 0, 1'b1);
        wait_done(300);
        ready_mode = 0;

        // Degenerate sizes.
        do_start(1, 1, 0, 0, 1'b0);
        @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_valid", bus.out_valid, 0);
            chk("t5_rd_en", longint'(bus.psum_rd_en), 0);
            chk("t5_done_low", done, 0);
        end
        do_start(0, 3, 3, 0, 1'b0);
        @(negedge clk);
        chk("t5_h0_done", done, 1);
        do_start(2, 0, 3, 0, 1'b0);
        @(negedge clk);
        chk("t5_w0_done", done, 1);

        // Start while busy is ignored.
        ready_mode = 2;
        fill_random(3, 8);
        do_start(3, 2, 4, 2, 1'b1);
        repeat (3) @(posedge clk);
        do_start(2, 3, 5, 1, 1'b0);
        wait_done(500);
        repeat (2) @(negedge clk);
        chk("t6_stays_idle", busy, 0);
        ready_mode = 0;

        // Reset mid-drain, then a fresh drain from col0/addr0.
        fill_pattern(2, 6);
        do_start(2, 2, 3, 0, 1'b1);
        h0 = hs;
        n = 0;
        while (hs < h0 + 5 && n < 50) begin @(negedge clk); n++; end
        chk("t7_reached_word5", hs >= h0 + 5, 1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_rd_en", longint'(bus.psum_rd_en), 0);
        chk("t7_rd_addr", bus.psum_rd_addr, 0);
        chk("t7_valid", bus.out_valid, 0);
        chk("t7_data", bus.out_data, 0);
        chk("t7_last", bus.out_last, 0);
        exp_q.delete();
        rd_q.delete();
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
        do_start(2, 2, 3, 0, 1'b1);
        wait_done(100);

        // Randomized tiles under random backpressure.
        ready_mode = 2;
        for (int it = 0; it < 8; it++) begin
            h = int'($urandom_range(1, 4));
            w = int'($urandom_range(1, 3));
            o = int'($urandom_range(1, 4));
            s = ($urandom_range(0, 5) == 0) ? int'($urandom_range(9, 31)) : int'($urandom_range(0, 8));
            fill_random(h, w * o);
            do_start(h, w, o, s, 1'b1);
            wait_done(2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
